// File: rtl/hc595_shift_driver_if.sv
// Upstream word handshake between the line scanner and the 74HC595 serialiser.
// The scanner holds the master side; the driver holds the slave side.
interface hc595_shift_driver_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output data_in, data_valid,
        input  data_ready, busy, done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, busy, done
    );
endinterface

// File: rtl/hc595_shift_driver.sv
// Handshaked serialiser for a 74HC595 chain: shifts one word out on SER/SRCLK, then pulses RCLK.
// Every output comes straight from a flop, so the pins are glitch-free and input-independent.
module hc595_shift_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 _rst,
    hc595_shift_driver_if.slave  up,
    output logic                 sclk,
    output logic                 rclk,
    output logic                 _srclr,
    output logic                 serial_data
);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOW   = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  ser_q, ser_d;
    logic                  sclk_q, sclk_d;
    logic                  rclk_q, rclk_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  srclr_q;
    logic                  tick;

    // The word is pre-shifted so the next bit to send always sits at the same end.
    logic                  first_bit, next_bit;
    logic [DATA_WIDTH-1:0] first_rest, next_rest;

    assign first_bit  = MSB_FIRST ? up.data_in[DATA_WIDTH-1] : up.data_in[0];
    assign first_rest = MSB_FIRST ? (up.data_in << 1) : (up.data_in >> 1);
    assign next_bit   = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
    assign next_rest  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
    assign tick       = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case can infer a latch.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ser_d   = ser_q;
        sclk_d  = sclk_q;
        rclk_d  = rclk_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (up.data_valid && ready_q) begin
                    state_d = S_LOW;
                    bit_d   = '0;
                    ser_d   = first_bit;
                    shift_d = first_rest;
                end
            end
            S_LOW: begin
                if (tick) begin
                    state_d = S_HIGH;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_LATCH;
                        rclk_d  = 1'b1;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q + 1'b1;
                        ser_d   = next_bit;
                        shift_d = next_rest;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (tick) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    rclk_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from the next state so ready is already high in the cycle done pulses.
        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ser_q   <= 1'b0;
            sclk_q  <= 1'b0;
            rclk_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            srclr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ser_q   <= ser_d;
            sclk_q  <= sclk_d;
            rclk_q  <= rclk_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            srclr_q <= 1'b1;
        end
    end

    assign up.data_ready = ready_q;
    assign up.busy       = busy_q;
    assign up.done       = done_q;
    assign sclk          = sclk_q;
    assign rclk          = rclk_q;
    assign _srclr        = srclr_q;
    assign serial_data   = ser_q;
endmodule

// File: tb/tb_hc595_shift_driver.sv
// Directed bench for hc595_shift_driver: a default instance (CLK_DIV=4, MSB first)
// and a fast LSB-first instance (CLK_DIV=1), each watched by a pin-level 595 monitor.
module tb_hc595_shift_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hc595_shift_driver_if #(.DATA_WIDTH(16)) bus_a ();
    hc595_shift_driver_if #(.DATA_WIDTH(16)) bus_b ();

    logic a_sclk, a_rclk, a_srclr, a_ser;
    logic b_sclk, b_rclk, b_srclr, b_ser;

    hc595_shift_driver #(.DATA_WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), ._rst(rst_n), .up(bus_a),
        .sclk(a_sclk), .rclk(a_rclk), ._srclr(a_srclr), .serial_data(a_ser)
    );

    hc595_shift_driver #(.DATA_WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), ._rst(rst_n), .up(bus_b),
        .sclk(b_sclk), .rclk(b_rclk), ._srclr(b_srclr), .serial_data(b_ser)
    );

    int vectors = 0;
    int miscompares = 0;

    // 595 model: SER sampled on each SRCLK rise; the first bit shifted in ends up at the MSB.
    int          a_rises = 0, a_rclk_hi = 0, a_pulses = 0, a_glitch = 0;
    logic [15:0] a_bits = '0;
    logic        a_sclk_p = 1'b0, a_rclk_p = 1'b0, a_ser_r = 1'b0;
    int          b_rises = 0, b_rclk_hi = 0, b_pulses = 0, b_glitch = 0;
    logic [15:0] b_bits = '0;
    logic        b_sclk_p = 1'b0, b_rclk_p = 1'b0, b_ser_r = 1'b0;

    always @(negedge clk) begin
        if (a_sclk === 1'b1 && a_sclk_p === 1'b0) begin
            a_bits  = {a_bits[14:0], a_ser};
            a_rises = a_rises + 1;
            a_ser_r = a_ser;
        end else if (a_sclk === 1'b1 && a_ser !== a_ser_r) begin
            a_glitch = a_glitch + 1;
        end
        if (a_rclk === 1'b1) a_rclk_hi = a_rclk_hi + 1;
        if (a_rclk === 1'b1 && a_rclk_p === 1'b0) a_pulses = a_pulses + 1;
        a_sclk_p = a_sclk;
        a_rclk_p = a_rclk;

        if (b_sclk === 1'b1 && b_sclk_p === 1'b0) begin
            b_bits  = {b_bits[14:0], b_ser};
            b_rises = b_rises + 1;
            b_ser_r = b_ser;
        end else if (b_sclk === 1'b1 && b_ser !== b_ser_r) begin
            b_glitch = b_glitch + 1;
        end
        if (b_rclk === 1'b1) b_rclk_hi = b_rclk_hi + 1;
        if (b_rclk === 1'b1 && b_rclk_p === 1'b0) b_pulses = b_pulses + 1;
        b_sclk_p = b_sclk;
        b_rclk_p = b_rclk;
    end

    task automatic clear_mon();
        a_rises = 0; a_rclk_hi = 0; a_pulses = 0; a_glitch = 0; a_bits = '0;
        b_rises = 0; b_rclk_hi = 0; b_pulses = 0; b_glitch = 0; b_bits = '0;
    endtask

    // Called one negedge after the accept edge; lat = edges from accept to done, -1 on timeout.
    task automatic wait_done(input bit on_b, output int lat);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if ((on_b ? bus_b.done : bus_a.done) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.data_valid = 1'b0; bus_a.data_in = '0;
        bus_b.data_valid = 1'b0; bus_b.data_in = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus_a.data_ready, bus_a.busy, bus_a.done, a_sclk, a_rclk, a_srclr, a_ser} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_a_outputs: got %b want 0000000",
                     {bus_a.data_ready, bus_a.busy, bus_a.done, a_sclk, a_rclk, a_srclr, a_ser});
        end
        vectors++;
        if ({bus_b.data_ready, bus_b.busy, bus_b.done, b_sclk, b_rclk, b_srclr, b_ser} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_b_outputs: got %b want 0000000",
                     {bus_b.data_ready, bus_b.busy, bus_b.done, b_sclk, b_rclk, b_srclr, b_ser});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus_a.data_ready, bus_a.busy, bus_a.done, a_sclk, a_rclk, a_srclr} !== 6'b100001) begin
            miscompares++;
            $display("FAIL release_a {ready,busy,done,sclk,rclk,srclr}: got %b want 100001",
                     {bus_a.data_ready, bus_a.busy, bus_a.done, a_sclk, a_rclk, a_srclr});
        end
        vectors++;
        if ({bus_b.data_ready, bus_b.busy, bus_b.done, b_sclk, b_rclk, b_srclr} !== 6'b100001) begin
            miscompares++;
            $display("FAIL release_b {ready,busy,done,sclk,rclk,srclr}: got %b want 100001",
                     {bus_b.data_ready, bus_b.busy, bus_b.done, b_sclk, b_rclk, b_srclr});
        end
    endtask

    task automatic test_single_word();
        int lat;
        clear_mon();
        bus_a.data_in = 16'hA5C3;
        bus_a.data_valid = 1'b1;
        @(negedge clk);
        bus_a.data_valid = 1'b0;
        vectors++;
        if ({bus_a.busy, bus_a.data_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_accept {busy,ready}: got %b want 10", {bus_a.busy, bus_a.data_ready});
        end
        wait_done(1'b0, lat);
        vectors++;
        if (lat != 132) begin miscompares++; $display("FAIL single_latency: got %0d want 132", lat); end
        vectors++;
        if (bus_a.data_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_ready_at_done: got %b want 1", bus_a.data_ready);
        end
        vectors++;
        if (a_rises != 16) begin miscompares++; $display("FAIL single_sclk_rises: got %0d want 16", a_rises); end
        vectors++;
        if (a_bits !== 16'hA5C3) begin miscompares++; $display("FAIL single_bits: got %h want a5c3", a_bits); end
        vectors++;
        if (a_rclk_hi != 4 || a_pulses != 1) begin
            miscompares++;
            $display("FAIL single_rclk: got %0d cycles/%0d pulses want 4/1", a_rclk_hi, a_pulses);
        end
        vectors++;
        if (a_glitch != 0) begin miscompares++; $display("FAIL single_ser_stable: got %0d changes want 0", a_glitch); end
        vectors++;
        if (a_ser !== 1'b1) begin miscompares++; $display("FAIL single_ser_hold: got %b want 1", a_ser); end
        @(negedge clk);
        vectors++;
        if ({bus_a.done, bus_a.busy} !== 2'b00) begin
            miscompares++; $display("FAIL single_done_pulse {done,busy}: got %b want 00", {bus_a.done, bus_a.busy});
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        clear_mon();
        bus_a.data_in = 16'h0180;
        bus_a.data_valid = 1'b1;
        @(negedge clk);
        bus_a.data_in = 16'hFE01;
        wait_done(1'b0, lat1);
        vectors++;
        if (lat1 != 132) begin miscompares++; $display("FAIL b2b_latency1: got %0d want 132", lat1); end
        vectors++;
        if (bus_a.data_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_ready_in_done: got %b want 1", bus_a.data_ready);
        end
        vectors++;
        if (a_bits !== 16'h0180) begin miscompares++; $display("FAIL b2b_bits1: got %h want 0180", a_bits); end
        @(negedge clk);
        bus_a.data_valid = 1'b0;
        vectors++;
        if ({bus_a.busy, bus_a.data_ready} !== 2'b10) begin
            miscompares++; $display("FAIL b2b_no_gap {busy,ready}: got %b want 10", {bus_a.busy, bus_a.data_ready});
        end
        wait_done(1'b0, lat2);
        vectors++;
        if (lat2 != 132) begin miscompares++; $display("FAIL b2b_latency2: got %0d want 132", lat2); end
        vectors++;
        if (a_bits !== 16'hFE01 || a_rises != 32) begin
            miscompares++; $display("FAIL b2b_bits2: got %h/%0d rises want fe01/32", a_bits, a_rises);
        end
        vectors++;
        if (a_pulses != 2 || a_rclk_hi != 8) begin
            miscompares++; $display("FAIL b2b_rclk: got %0d pulses/%0d cycles want 2/8", a_pulses, a_rclk_hi);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_inputs();
        int lat;
        int ready_hi;
        clear_mon();
        ready_hi = 0;
        lat = -1;
        bus_a.data_in = 16'hFFFF;
        bus_a.data_valid = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 400; i++) begin
            bus_a.data_in = 16'($urandom);
            bus_a.data_valid = i[0];
            @(negedge clk);
            if (bus_a.done === 1'b1) begin
                bus_a.data_valid = 1'b0;
                lat = i;
                break;
            end
            if (bus_a.data_ready !== 1'b0) ready_hi++;
        end
        vectors++;
        if (lat != 132) begin miscompares++; $display("FAIL ignore_latency: got %0d want 132", lat); end
        vectors++;
        if (ready_hi != 0) begin miscompares++; $display("FAIL ignore_ready_low: got %0d high cycles want 0", ready_hi); end
        vectors++;
        if (a_bits !== 16'hFFFF || a_rises != 16) begin
            miscompares++; $display("FAIL ignore_bits: got %h/%0d rises want ffff/16", a_bits, a_rises);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle_after: got busy %b want 0", bus_a.busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit reached;
        clear_mon();
        reached = 1'b0;
        bus_a.data_in = 16'hC3C3;
        bus_a.data_valid = 1'b1;
        @(negedge clk);
        bus_a.data_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_rises >= 8) begin reached = 1'b1; break; end
        end
        vectors++;
        if (!reached) begin miscompares++; $display("FAIL mid_reach_bit7: got %0d rises want 8", a_rises); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_a.data_ready, bus_a.busy, bus_a.done, a_sclk, a_rclk, a_srclr, a_ser} !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_async_clear: got %b want 0000000",
                     {bus_a.data_ready, bus_a.busy, bus_a.done, a_sclk, a_rclk, a_srclr, a_ser});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_pulses != 0) begin miscompares++; $display("FAIL mid_no_rclk: got %0d pulses want 0", a_pulses); end
        vectors++;
        if ({bus_a.data_ready, a_srclr} !== 2'b11) begin
            miscompares++; $display("FAIL mid_release {ready,srclr}: got %b want 11", {bus_a.data_ready, a_srclr});
        end
        clear_mon();
        bus_a.data_in = 16'h1234;
        bus_a.data_valid = 1'b1;
        @(negedge clk);
        bus_a.data_valid = 1'b0;
        wait_done(1'b0, lat);
        vectors++;
        if (lat != 132) begin miscompares++; $display("FAIL mid_next_latency: got %0d want 132", lat); end
        vectors++;
        if (a_bits !== 16'h1234 || a_rises != 16 || a_pulses != 1) begin
            miscompares++;
            $display("FAIL mid_next_word: got %h/%0d rises/%0d pulses want 1234/16/1", a_bits, a_rises, a_pulses);
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_fast();
        int lat;
        clear_mon();
        bus_b.data_in = 16'h0001;
        bus_b.data_valid = 1'b1;
        @(negedge clk);
        bus_b.data_valid = 1'b0;
        wait_done(1'b1, lat);
        vectors++;
        if (lat != 33) begin miscompares++; $display("FAIL lsb_latency: got %0d want 33", lat); end
        vectors++;
        if (b_bits !== 16'h8000 || b_rises != 16) begin
            miscompares++; $display("FAIL lsb_bits: got %h/%0d rises want 8000/16", b_bits, b_rises);
        end
        vectors++;
        if (b_rclk_hi != 1 || b_pulses != 1) begin
            miscompares++; $display("FAIL lsb_rclk: got %0d cycles/%0d pulses want 1/1", b_rclk_hi, b_pulses);
        end
        vectors++;
        if (b_glitch != 0) begin miscompares++; $display("FAIL lsb_ser_stable: got %0d changes want 0", b_glitch); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignore_inputs();
        test_reset_mid();
        test_lsb_fast();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog");
    end
endmodule
